sram_emulation_responder: RTL and testbench

- Responder end of the 18-bit-address / 16-bit-data / active-low write-enable SRAM interface driven by the BIST and other initiators.
- Emulates the external SRAM's timing: read data returns two clocks after the address is presented. This lets the BIST run in simulation and on-chip without the board SRAM.
- Stores a compressed syndrome (write_data XOR address[15:0]) in a small on-chip array aliased by the low address bits.
- Adds fault injection and access counters for negative testing of the initiator.

---
 rtl/sram_emu_pkg.sv | 21 ++
 rtl/sram_emulation_responder_if.sv | 20 ++
 rtl/sram_syndrome_ram.sv | 25 ++
 rtl/sram_emulation_responder.sv | 121 ++++++++++++
 tb/tb_sram_emulation_responder.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_emu_pkg.sv
// Shared types and widths for the SRAM emulation responder and its initiators.
package sram_emu_pkg;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;

  typedef enum logic {
    S_INIT,
    S_READY
  } state_e;

  // Replace the masked bits of a read word with the forced values.
  function automatic logic [SRAM_DATA_W-1:0] apply_stuck(
    input logic [SRAM_DATA_W-1:0] data,
    input logic [SRAM_DATA_W-1:0] mask,
    input logic [SRAM_DATA_W-1:0] value
  );
    return (data & ~mask) | (value & mask);
  endfunction

endpackage

// File: rtl/sram_emulation_responder_if.sv
// External-SRAM-style bus: 18-bit address, 16-bit data, active-low write enable.
interface sram_emulation_responder_if;
  import sram_emu_pkg::*;

  logic [SRAM_ADDR_W-1:0] SRAM_address;
  logic [SRAM_DATA_W-1:0] SRAM_write_data;
  logic                   SRAM_we_n;
  logic [SRAM_DATA_W-1:0] SRAM_read_data;

  modport master (
    output SRAM_address, SRAM_write_data, SRAM_we_n,
    input  SRAM_read_data
  );

  modport slave (
    input  SRAM_address, SRAM_write_data, SRAM_we_n,
    output SRAM_read_data
  );

endinterface

// File: rtl/sram_syndrome_ram.sv
// Single-port synchronous-read RAM holding the compressed syndrome words.
module sram_syndrome_ram #(
  parameter int DEPTH_W = 10,
  parameter int DATA_W  = 16
) (
  input  logic               Clock,
  input  logic               we,
  input  logic               re,
  input  logic [DEPTH_W-1:0] index,
  input  logic [DATA_W-1:0]  write_data,
  output logic [DATA_W-1:0]  read_data
);

  logic [DATA_W-1:0] mem [2**DEPTH_W];

  // NOTE: neither the array nor its read register is reset, so this maps onto
  // block RAM; the responder's post-reset clear sweep initialises the contents.
  always_ff @(posedge Clock) begin
    if (we)
      mem[index] <= write_data;
    else if (re)
      read_data <= mem[index];
  end

endmodule

// File: rtl/sram_emulation_responder.sv
// SRAM responder: two-cycle read latency, syndrome storage, fault injection and access counters.
module sram_emulation_responder
  import sram_emu_pkg::*;
#(
  parameter int DEPTH_W = 10,
  parameter int COUNT_W = 20
) (
  input  logic                   Clock,
  input  logic                   Resetn,
  sram_emulation_responder_if.slave bus,
  output logic                   Ready,
  input  logic                   Fault_enable,
  input  logic [SRAM_ADDR_W-1:0] Fault_address,
  input  logic [SRAM_DATA_W-1:0] Fault_flip_mask,
  input  logic [SRAM_DATA_W-1:0] Stuck_mask,
  input  logic [SRAM_DATA_W-1:0] Stuck_value,
  output logic [COUNT_W-1:0]     Write_count,
  output logic [COUNT_W-1:0]     Read_count
);

  state_e state, state_nxt;

  logic [DEPTH_W-1:0]     clear_cnt;
  logic                   s1_valid;
  logic                   s1_we_n;
  logic [SRAM_ADDR_W-1:0] s1_addr;
  logic [SRAM_DATA_W-1:0] s1_wd;
  logic                   s2_have;
  logic [SRAM_DATA_W-1:0] s2_addr;

  logic                   ram_we, ram_re;
  logic [DEPTH_W-1:0]     ram_index;
  logic [SRAM_DATA_W-1:0] ram_wd, ram_rdata;
  logic                   fault_hit;

  assign fault_hit = Fault_enable && (s1_addr == Fault_address);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= S_INIT;
    else         state <= state_nxt;
  end

  // NOTE: every output of this block is given a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_index = s1_addr[DEPTH_W-1:0];
    ram_wd    = s1_wd ^ s1_addr[SRAM_DATA_W-1:0] ^ (fault_hit ? Fault_flip_mask : '0);
    case (state)
      S_INIT: begin
        ram_we    = 1'b1;
        ram_index = clear_cnt;
        ram_wd    = '0;
        if (clear_cnt == '1) state_nxt = S_READY;
      end
      S_READY: begin
        if (s1_valid) begin
          ram_we = !s1_we_n;
          ram_re = s1_we_n;
        end
      end
      default: state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      Ready       <= 1'b0;
      clear_cnt   <= '0;
      s1_valid    <= 1'b0;
      s1_we_n     <= 1'b1;
      s1_addr     <= '0;
      s1_wd       <= '0;
      s2_have     <= 1'b0;
      s2_addr     <= '0;
      Write_count <= '0;
      Read_count  <= '0;
    end else begin
      Ready <= (state_nxt == S_READY);
      if (state == S_INIT)
        clear_cnt <= clear_cnt + DEPTH_W'(1);
      // Accesses are only accepted (and counted) once the clear sweep is done.
      if (state == S_READY) begin
        s1_valid <= 1'b1;
        s1_we_n  <= bus.SRAM_we_n;
        s1_addr  <= bus.SRAM_address;
        s1_wd    <= bus.SRAM_write_data;
        if (!bus.SRAM_we_n) begin
          if (Write_count != '1) Write_count <= Write_count + COUNT_W'(1);
        end else begin
          if (Read_count != '1) Read_count <= Read_count + COUNT_W'(1);
        end
      end
      if (ram_re) begin
        s2_have <= 1'b1;
        s2_addr <= s1_addr[SRAM_DATA_W-1:0];
      end
    end
  end

  sram_syndrome_ram #(
    .DEPTH_W (DEPTH_W),
    .DATA_W  (SRAM_DATA_W)
  ) u_ram (
    .Clock      (Clock),
    .we         (ram_we),
    .re         (ram_re),
    .index      (ram_index),
    .write_data (ram_wd),
    .read_data  (ram_rdata)
  );

  // Read data and address both come from registers that update only on reads,
  // so the output holds across writes; stuck bits are applied live.
  assign bus.SRAM_read_data = s2_have ? apply_stuck(ram_rdata ^ s2_addr, Stuck_mask, Stuck_value)
                                      : '0;

endmodule

// File: tb/tb_sram_emulation_responder.sv
// Self-checking bench: directed vector table, hand sequences and a random run against a reference model.
module tb_sram_emulation_responder;

  localparam int DEPTH_W = 10;
  localparam int COUNT_W = 12;
  localparam int CMAX    = (1 << COUNT_W) - 1;

  logic               Clock;
  logic               Resetn;
  logic               Ready;
  logic               Fault_enable;
  logic [17:0]        Fault_address;
  logic [15:0]        Fault_flip_mask;
  logic [15:0]        Stuck_mask;
  logic [15:0]        Stuck_value;
  logic [COUNT_W-1:0] Write_count;
  logic [COUNT_W-1:0] Read_count;

  sram_emulation_responder_if bus ();

  sram_emulation_responder #(.DEPTH_W(DEPTH_W), .COUNT_W(COUNT_W)) dut (
    .Clock           (Clock),
    .Resetn          (Resetn),
    .bus             (bus),
    .Ready           (Ready),
    .Fault_enable    (Fault_enable),
    .Fault_address   (Fault_address),
    .Fault_flip_mask (Fault_flip_mask),
    .Stuck_mask      (Stuck_mask),
    .Stuck_value     (Stuck_value),
    .Write_count     (Write_count),
    .Read_count      (Read_count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: one syndrome word per low-address index, plus the
  // two-access delay between a read being presented and its data appearing.
  logic [15:0] mdl_mem [1 << DEPTH_W];
  logic        mdl_have;
  logic [15:0] mdl_raw;
  logic        pend_valid;
  logic [15:0] pend_raw;
  int          mdl_wr, mdl_rd;

  typedef struct {
    logic [17:0] addr;
    logic        we_n;
    logic [15:0] wd;
    logic [15:0] exp;  // read data seen two cycles after this access
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] stuck(input logic [15:0] raw);
    return (raw & ~Stuck_mask) | (Stuck_value & Stuck_mask);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < (1 << DEPTH_W); i++) mdl_mem[i] = 16'h0;
    mdl_have   = 1'b0;
    mdl_raw    = 16'h0;
    pend_valid = 1'b0;
    pend_raw   = 16'h0;
    mdl_wr     = 0;
    mdl_rd     = 0;
  endtask

  // Present one access for one cycle, then compare read data against the model.
  task automatic apply(input logic [17:0] a, input logic we_n, input logic [15:0] d);
    logic        rd_now;
    logic [15:0] rd_raw, syn;
    bus.SRAM_address    = a;
    bus.SRAM_we_n       = we_n;
    bus.SRAM_write_data = d;
    rd_now = 1'b0;
    rd_raw = 16'h0;
    if (Ready) begin
      if (!we_n) begin
        syn = d ^ a[15:0];
        if (Fault_enable && a == Fault_address) syn = syn ^ Fault_flip_mask;
        mdl_mem[a[DEPTH_W-1:0]] = syn;
        if (mdl_wr < CMAX) mdl_wr++;
      end else begin
        rd_now = 1'b1;
        rd_raw = mdl_mem[a[DEPTH_W-1:0]] ^ a[15:0];
        if (mdl_rd < CMAX) mdl_rd++;
      end
    end
    @(posedge Clock);
    #1;
    if (pend_valid) begin
      mdl_have = 1'b1;
      mdl_raw  = pend_raw;
    end
    pend_valid = rd_now;
    pend_raw   = rd_raw;
    check("model_read_data", 32'(bus.SRAM_read_data), 32'(mdl_have ? stuck(mdl_raw) : 16'h0));
  endtask

  vec_t        vecs [8];
  logic [17:0] a;
  logic [15:0] last_bad_data;
  logic [17:0] last_bad_addr;
  int          bad_cnt;
  int          waited;

  initial begin
    vecs[0] = '{18'h00005, 1'b0, 16'h1234, 16'h0000};
    vecs[1] = '{18'h00005, 1'b1, 16'h0000, 16'h1234};
    vecs[2] = '{18'h00405, 1'b1, 16'h0000, 16'h1634};
    vecs[3] = '{18'h00405, 1'b0, 16'hAAAA, 16'h1634};
    vecs[4] = '{18'h00005, 1'b1, 16'h0000, 16'hAEAA};
    vecs[5] = '{18'h3FFFF, 1'b0, 16'hFFFF, 16'hAEAA};
    vecs[6] = '{18'h003FF, 1'b1, 16'h0000, 16'h03FF};
    vecs[7] = '{18'h10005, 1'b1, 16'h0000, 16'hAEAA};

    Resetn              = 1'b0;
    Fault_enable        = 1'b0;
    Fault_address       = 18'h0;
    Fault_flip_mask     = 16'h0;
    Stuck_mask          = 16'h0;
    Stuck_value         = 16'h0;
    bus.SRAM_address    = 18'h0;
    bus.SRAM_we_n       = 1'b1;
    bus.SRAM_write_data = 16'h0;
    model_reset();

    #1;
    check("reset_ready", 32'(Ready), 32'h0);
    check("reset_read_data", 32'(bus.SRAM_read_data), 32'h0);
    check("reset_write_count", 32'(Write_count), 32'h0);
    check("reset_read_count", 32'(Read_count), 32'h0);
    repeat (3) @(posedge Clock);
    #1;
    Resetn = 1'b1;

    // Clear sweep: Ready low for 1024 cycles, high on the 1025th; accesses ignored.
    check("ready_cycle1", 32'(Ready), 32'h0);
    for (int k = 1; k <= (1 << DEPTH_W); k++) begin
      apply(18'h00005, 1'b0, 16'hBEEF);
      check("ready_during_clear", 32'(Ready), 32'(k == (1 << DEPTH_W)));
    end
    check("init_write_count", 32'(Write_count), 32'h0);
    check("init_read_count", 32'(Read_count), 32'h0);

    // Directed table: each vector's expectation appears two cycles after it.
    for (int i = 0; i < 8; i++) begin
      apply(vecs[i].addr, vecs[i].we_n, vecs[i].wd);
      if (i > 0) check($sformatf("vec%0d_read_data", i - 1), 32'(bus.SRAM_read_data), 32'(vecs[i-1].exp));
    end
    apply(18'h00100, 1'b0, 16'h0100);
    check("vec7_read_data", 32'(bus.SRAM_read_data), 32'(vecs[7].exp));
    check("table_write_count", 32'(Write_count), 32'd4);
    check("table_read_count", 32'(Read_count), 32'd5);

    // Stuck bits applied live to the held output.
    apply(18'h0F000, 1'b0, 16'hF000);
    apply(18'h0F000, 1'b1, 16'h0000);
    apply(18'h00000, 1'b0, 16'h0000);
    check("stuck_off", 32'(bus.SRAM_read_data), 32'hF000);
    Stuck_mask  = 16'h8000;
    Stuck_value = 16'h0000;
    #1;
    check("stuck_bit15_low", 32'(bus.SRAM_read_data), 32'h7000);
    Stuck_mask = 16'h0000;
    #1;
    check("stuck_cleared", 32'(bus.SRAM_read_data), 32'hF000);

    // Fault injection over a small address-as-data sweep.
    Fault_enable    = 1'b1;
    Fault_address   = 18'h2ABCD;
    Fault_flip_mask = 16'h0001;
    for (int i = 0; i < 32; i++) begin
      a = 18'h2ABC0 + 18'(i);
      apply(a, 1'b0, a[15:0]);
    end
    bad_cnt       = 0;
    last_bad_addr = 18'h0;
    last_bad_data = 16'h0;
    for (int i = 0; i <= 32; i++) begin
      a = 18'h2ABC0 + 18'(i);
      apply(a, 1'b1, 16'h0);
      if (i > 0 && bus.SRAM_read_data != 16'(a[15:0] - 16'd1)) begin
        bad_cnt++;
        last_bad_addr = a - 18'd1;
        last_bad_data = bus.SRAM_read_data;
      end
    end
    check("fault_mismatch_count", 32'(bad_cnt), 32'd1);
    check("fault_mismatch_addr", 32'(last_bad_addr), 32'h2ABCD);
    check("fault_mismatch_data", 32'(last_bad_data), 32'hABCC);
    check("fault_write_count", 32'(Write_count), 32'(mdl_wr));
    check("fault_read_count", 32'(Read_count), 32'(mdl_rd));

    // Random traffic with aliasing, fault hits and stuck bits; read counter saturates.
    Fault_flip_mask = 16'($urandom_range(1, 16'hFFFF));
    for (int i = 0; i < 7000; i++) begin
      if (i == 3500) begin
        Stuck_mask  = 16'($urandom);
        Stuck_value = 16'($urandom);
      end
      a = 18'($urandom);
      if ($urandom_range(0, 1) == 1) a[DEPTH_W-1:0] = 10'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) a = Fault_address;
      apply(a, ($urandom_range(0, 99) >= 15), 16'($urandom));
    end
    check("random_write_count", 32'(Write_count), 32'(mdl_wr));
    check("random_read_count", 32'(Read_count), 32'(mdl_rd));
    check("read_count_saturated", 32'(Read_count), 32'(CMAX));
    Stuck_mask   = 16'h0;
    Fault_enable = 1'b0;

    // Asynchronous reset with reads in flight.
    apply(18'h00005, 1'b1, 16'h0);
    apply(18'h00006, 1'b1, 16'h0);
    #2;
    Resetn = 1'b0;
    #1;
    check("async_reset_read_data", 32'(bus.SRAM_read_data), 32'h0);
    check("async_reset_ready", 32'(Ready), 32'h0);
    check("async_reset_write_count", 32'(Write_count), 32'h0);
    check("async_reset_read_count", 32'(Read_count), 32'h0);
    model_reset();
    @(posedge Clock);
    #1;
    Resetn = 1'b1;
    waited = 0;
    while (!Ready && waited < 2000) begin
      apply(18'h00007, 1'b1, 16'h0);
      waited++;
    end
    check("reclear_ready", 32'(Ready), 32'h1);
    check("reclear_cycles", 32'(waited), 32'(1 << DEPTH_W));
    apply(18'h00005, 1'b1, 16'h0);
    apply(18'h00000, 1'b1, 16'h0);
    check("reclear_read_data", 32'(bus.SRAM_read_data), 32'h0005);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
